// File: rtl/trig_pkg.sv
// Shared definitions for the trigger-ID event path: event widths, record layout
// and field offsets the SPI serializer uses to slice a 40-bit event.
package trig_pkg;
    localparam int ID_W  = 16;
    localparam int TS_W  = 24;
    localparam int EVT_W = ID_W + TS_W;

    localparam int EVT_TS_LSB = 0;
    localparam int EVT_TS_MSB = TS_W - 1;
    localparam int EVT_ID_LSB = TS_W;
    localparam int EVT_ID_MSB = EVT_W - 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts;
    } trig_evt_t;

    function automatic trig_evt_t evt_pack(input logic [ID_W-1:0] id, input logic [TS_W-1:0] ts);
        trig_evt_t e;
        e.id = id;
        e.ts = ts;
        return e;
    endfunction
endpackage

// File: rtl/trig_event_ram.sv
// Simple dual-port event store: synchronous write, registered read.
// A read of the address being written in the same cycle returns the old word.
module trig_event_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 40,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/trig_event_fifo.sv
// Timestamped trigger-ID event queue drained by the MCU over SPI.
// First-word-fall-through head, overflow drop counter, active-low pending interrupt.
module trig_event_fifo #(
    parameter int DEPTH = 16,
    parameter int TS_W  = trig_pkg::TS_W,
    parameter int ID_W  = trig_pkg::ID_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1,
    localparam int EW   = ID_W + TS_W
) (
    input  logic            pll_clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [ID_W-1:0] id_data,
    input  logic            ts_clear,
    input  logic            pop,
    output logic [EW-1:0]   head_data,
    output logic            empty,
    output logic            full,
    output logic [CW-1:0]   count,
    output logic [7:0]      dropped,
    input  logic            drop_clr,
    output logic            interrupt
);
    logic [TS_W-1:0] ts_q;
    logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      drop_q, drop_d;
    logic            empty_q, full_q, irq_n_q;
    logic            byp_q;
    logic [EW-1:0]   byp_data_q, ram_rdata, wdata;
    logic            push_acc, pop_acc, ovf, byp, ram_re, full_d;

    always_comb begin
        pop_acc  = pop && !empty_q;
        push_acc = id_valid && (!full_q || pop);
        ovf      = id_valid && !push_acc;
        wdata    = {id_data, ts_q};
        wr_d     = wr_q + {{AW{1'b0}}, push_acc};
        rd_d     = rd_q + {{AW{1'b0}}, pop_acc};
        count_d  = count_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
        full_d   = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
        // The incoming word becomes the head when nothing else is left ahead of it;
        // the RAM cannot return it this cycle, so it is captured directly.
        byp      = push_acc && (count_q == {{AW{1'b0}}, pop_acc});
        // Skip the read when the queue drains so head_data keeps its last value.
        ram_re   = (count_d != '0) && !byp;
        drop_d   = drop_q;
        if (drop_clr)
            drop_d = ovf ? 8'd1 : 8'd0;
        else if (ovf && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge pll_clk) begin
        if (!reset) begin
            ts_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            irq_n_q    <= 1'b1;
            byp_q      <= 1'b1;
            byp_data_q <= '0;
        end else begin
            ts_q    <= ts_clear ? '0 : ts_q + 1'b1;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            empty_q <= (count_d == '0);
            full_q  <= full_d;
            irq_n_q <= (count_d == '0);
            if (byp) begin
                byp_q      <= 1'b1;
                byp_data_q <= wdata;
            end else if (ram_re) begin
                byp_q      <= 1'b0;
            end
        end
    end

    trig_event_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
        .clk   (pll_clk),
        .we    (push_acc),
        .waddr (wr_q[AW-1:0]),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (rd_d[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign head_data = byp_q ? byp_data_q : ram_rdata;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign dropped   = drop_q;
    assign interrupt = irq_n_q;
endmodule
